dcsk_rx_demod: RTL and testbench

//   Non-coherent DCSK demodulator fed by the TX serial chip stream (o_tx).

---
 rtl/dcsk_rx_demod.sv | 136 +++++++++++++
 tb/tb_dcsk_rx_demod.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dcsk_rx_demod.sv
// dcsk_rx_demod
//   Non-coherent DCSK demodulator for a serial chip stream. Each bit period
//   is SF reference chips followed by SF data chips. The data chips equal the
//   reference for a 1 and are inverted for a 0. The block stores the
//   reference half, counts how many data chips agree with it, decides each
//   bit, and assembles an MSB-first message.
//
// Ports
//   i_clk     system clock, all state on posedge
//   i_arst_n  asynchronous active-low reset
//   i_rx      received chip, one per cycle
//   i_start   pulse: i_rx carries the first reference chip of bit 0
//   i_sf      SF id: 00=8, 01=16, 10=32, 11=64 chips per half-bit
//   o_msg     last decoded message, held until the next o_valid
//   o_valid   one-cycle pulse while o_msg holds a newly decoded frame
//   o_busy    high while the block is receiving reference or data chips
//   o_tie     qualified by o_valid: at least one bit had agree == SF/2
module dcsk_rx_demod #(
    parameter int MSG_W  = 32,
    parameter int MAX_SF = 64
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_rx,
    input  logic             i_start,
    input  logic [1:0]       i_sf,
    output logic [MSG_W-1:0] o_msg,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_tie
);
    localparam int CW = $clog2(MAX_SF);    // chip index width
    localparam int AW = $clog2(MAX_SF + 1); // agreement count, holds MAX_SF
    localparam int BW = $clog2(MSG_W);      // bit index width

    typedef enum logic [1:0] {S_IDLE, S_REF, S_DATA, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     sf_m1;      // latched SF-1
    logic [CW-1:0]     chip_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [AW-1:0]     agree;
    logic [MAX_SF-1:0] ref_q;
    logic [MSG_W-1:0]  msg_sr;
    logic              tie_flag;

    logic              last_chip, last_bit, match, bit_dec, tie_now;
    logic [AW-1:0]     agree_fin, half;
    logic [MSG_W-1:0]  msg_nxt;

    assign last_chip = (chip_cnt == sf_m1);
    assign last_bit  = (bit_cnt == BW'(MSG_W - 1));
    assign match     = (i_rx == ref_q[chip_cnt]);
    // The decision uses the count including the chip sampled this cycle.
    assign agree_fin = agree + AW'(match);
    assign half      = AW'(({1'b0, sf_m1} + AW'(1)) >> 1);
    assign bit_dec   = (agree_fin > half);
    assign tie_now   = (agree_fin == half);
    assign msg_nxt   = {msg_sr[MSG_W-2:0], bit_dec};

    assign o_valid = (state_q == S_DONE);
    assign o_busy  = (state_q == S_REF) || (state_q == S_DATA);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_start)   state_d = S_REF;
            S_REF:  if (last_chip) state_d = S_DATA;
            S_DATA: if (last_chip) state_d = last_bit ? S_DONE : S_REF;
            S_DONE:                state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            sf_m1    <= '0;
            chip_cnt <= '0;
            bit_cnt  <= '0;
            agree    <= '0;
            ref_q    <= '0;
            msg_sr   <= '0;
            tie_flag <= 1'b0;
            o_msg    <= '0;
            o_tie    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        // The start cycle already carries reference chip 0.
                        sf_m1    <= CW'((8 << i_sf) - 1);
                        ref_q[0] <= i_rx;
                        chip_cnt <= CW'(1);
                        bit_cnt  <= '0;
                        agree    <= '0;
                        tie_flag <= 1'b0;
                    end
                end
                S_REF: begin
                    ref_q[chip_cnt] <= i_rx;
                    if (last_chip) begin
                        chip_cnt <= '0;
                        agree    <= '0;
                    end else begin
                        chip_cnt <= chip_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (last_chip) begin
                        msg_sr   <= msg_nxt;
                        tie_flag <= tie_flag | tie_now;
                        bit_cnt  <= bit_cnt + BW'(1);
                        chip_cnt <= '0;
                        agree    <= '0;
                        // Outputs are loaded on the edge into DONE so they are
                        // already stable in the cycle o_valid is asserted.
                        if (last_bit) begin
                            o_msg <= msg_nxt;
                            o_tie <= tie_flag | tie_now;
                        end
                    end else begin
                        agree    <= agree_fin;
                        chip_cnt <= chip_cnt + CW'(1);
                    end
                end
                S_DONE: tie_flag <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dcsk_rx_demod.sv
module tb_dcsk_rx_demod;
    logic        clk, rst_n, rx, start;
    logic [1:0]  sf_id;
    logic [31:0] msg;
    logic        valid, busy, tie;

    int n_cmp = 0;
    int n_err = 0;

    // results of the most recent run_frame
    int          got_lat;
    int          n_valid;
    logic [31:0] got_msg;
    logic        got_tie;
    logic [7:0]  lfsr;

    dcsk_rx_demod #(.MSG_W(32), .MAX_SF(64)) dut (
        .i_clk(clk), .i_arst_n(rst_n), .i_rx(rx), .i_start(start), .i_sf(sf_id),
        .o_msg(msg), .o_valid(valid), .o_busy(busy), .o_tie(tie)
    );

    always #5 clk = ~clk;

    // Sample outputs at a negedge; record the first o_valid and its payload.
    task automatic sample(input int cyc);
        if (valid === 1'b1) begin
            n_valid++;
            if (got_lat < 0) begin
                got_lat = cyc;
                got_msg = msg;
                got_tie = tie;
            end
        end
    endtask

    // Drives one complete frame. ref_mode: 0 = 0x5A per bit, 1 = random,
    // 2 = 8-bit LFSR. nflip data chips are inverted in every bit; bit index
    // tie_b (0 = message bit 31) gets SF/2 inverted chips instead. At chip
    // pulse_at a spurious i_start is raised and i_sf changes for the rest.
    task automatic run_frame(input logic [1:0] sfid, input logic [31:0] m,
                             input int ref_mode, input int nflip,
                             input int tie_b, input int pulse_at);
        int sf;
        int cyc;
        logic [7:0]  pat;
        logic [63:0] rf, dt;
        sf = 8 << sfid;
        pat = 8'h5A;
        cyc = 0;
        got_lat = -1;
        n_valid = 0;
        got_msg = '0;
        got_tie = 1'b0;
        for (int b = 0; b < 32; b++) begin
            int nf;
            for (int i = 0; i < sf; i++) begin
                case (ref_mode)
                    0: rf[i] = pat[7 - (i % 8)];
                    1: rf[i] = 1'($urandom_range(0, 1));
                    default: begin
                        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                        rf[i] = lfsr[0];
                    end
                endcase
                dt[i] = m[31 - b] ? rf[i] : ~rf[i];
            end
            nf = (b == tie_b) ? sf / 2 : nflip;
            for (int i = 0; i < nf; i++) dt[i] = ~dt[i];
            for (int h = 0; h < 2; h++) begin
                for (int i = 0; i < sf; i++) begin
                    @(negedge clk);
                    sample(cyc);
                    start = (cyc == 0) || (cyc == pulse_at);
                    sf_id = (pulse_at >= 0 && cyc >= pulse_at) ? ~sfid : sfid;
                    rx    = (h == 0) ? rf[i] : dt[i];
                    cyc++;
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sample(cyc);
            start = 1'b0;
            rx    = 1'b0;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (msg !== 32'h0) begin n_err++; $display("FAIL reset_msg got %h want 0", msg); end
        n_cmp++; if (tie !== 1'b0) begin n_err++; $display("FAIL reset_tie got %0b want 0", tie); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sf8();
        run_frame(2'b00, 32'hA5A50F0F, 0, 0, -1, -1);
        n_cmp++; if (got_lat !== 512) begin n_err++; $display("FAIL sf8_latency got %0d want 512", got_lat); end
        n_cmp++; if (got_msg !== 32'hA5A50F0F) begin n_err++; $display("FAIL sf8_msg got %h want a5a50f0f", got_msg); end
        n_cmp++; if (got_tie !== 1'b0) begin n_err++; $display("FAIL sf8_tie got %0b want 0", got_tie); end
        n_cmp++; if (n_valid !== 1) begin n_err++; $display("FAIL sf8_pulse_len got %0d want 1", n_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sf8_idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_sf64();
        run_frame(2'b11, 32'hFFFFFFFF, 1, 0, -1, -1);
        n_cmp++; if (got_lat !== 4096) begin n_err++; $display("FAIL sf64_latency got %0d want 4096", got_lat); end
        n_cmp++; if (got_msg !== 32'hFFFFFFFF) begin n_err++; $display("FAIL sf64_msg got %h want ffffffff", got_msg); end
        n_cmp++; if (msg !== 32'hFFFFFFFF) begin n_err++; $display("FAIL sf64_msg_hold got %h want ffffffff", msg); end
    endtask

    task automatic test_tie();
        // Message bit 31 is 1 but its data half agrees on exactly 8 of 16 chips.
        run_frame(2'b01, 32'hC3A51E69, 0, 0, 0, -1);
        n_cmp++; if (got_lat !== 1024) begin n_err++; $display("FAIL tie_latency got %0d want 1024", got_lat); end
        n_cmp++; if (got_msg !== 32'h43A51E69) begin n_err++; $display("FAIL tie_msg got %h want 43a51e69", got_msg); end
        n_cmp++; if (got_tie !== 1'b1) begin n_err++; $display("FAIL tie_flag got %0b want 1", got_tie); end
    endtask

    task automatic test_flip();
        // Agree count 5 of 8 for ones, 3 of 8 for zeros: decisions still exact,
        // and the tie flag from the previous frame must not carry over.
        run_frame(2'b00, 32'h12345678, 0, 3, -1, -1);
        n_cmp++; if (got_lat !== 512) begin n_err++; $display("FAIL flip_latency got %0d want 512", got_lat); end
        n_cmp++; if (got_msg !== 32'h12345678) begin n_err++; $display("FAIL flip_msg got %h want 12345678", got_msg); end
        n_cmp++; if (got_tie !== 1'b0) begin n_err++; $display("FAIL flip_tie got %0b want 0", got_tie); end
    endtask

    task automatic test_ignore_start();
        run_frame(2'b00, 32'h0F0FA5A5, 0, 0, -1, 100);
        n_cmp++; if (got_lat !== 512) begin n_err++; $display("FAIL ignore_latency got %0d want 512", got_lat); end
        n_cmp++; if (got_msg !== 32'h0F0FA5A5) begin n_err++; $display("FAIL ignore_msg got %h want 0f0fa5a5", got_msg); end
        n_cmp++; if (n_valid !== 1) begin n_err++; $display("FAIL ignore_pulse_len got %0d want 1", n_valid); end
    endtask

    task automatic test_reset_mid();
        int nv;
        sf_id = 2'b00;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            start = (c == 0);
            rx    = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before got %0b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy_reset got %0b want 0", busy); end
        n_cmp++; if (msg !== 32'h0) begin n_err++; $display("FAIL mid_msg_reset got %h want 0", msg); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rx = 1'($urandom_range(0, 1));
            if (valid === 1'b1) nv++;
        end
        n_cmp++; if (nv !== 0) begin n_err++; $display("FAIL mid_no_valid got %0d pulses want 0", nv); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_loopback();
        lfsr = 8'h3C;
        run_frame(2'b01, 32'hDEADBEEF, 2, 0, -1, -1);
        n_cmp++; if (got_lat !== 1024) begin n_err++; $display("FAIL loop_latency got %0d want 1024", got_lat); end
        n_cmp++; if (got_msg !== 32'hDEADBEEF) begin n_err++; $display("FAIL loop_msg got %h want deadbeef", got_msg); end
        n_cmp++; if (got_tie !== 1'b0) begin n_err++; $display("FAIL loop_tie got %0b want 0", got_tie); end
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        rx    = 1'b0;
        start = 1'b0;
        sf_id = 2'b00;
        lfsr  = 8'h3C;
        test_reset();
        test_sf8();
        test_sf64();
        test_tie();
        test_flip();
        test_ignore_start();
        test_reset_mid();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
